// File: rtl/spin_control_input_pkg.sv
// Shared constants for the spinner front-panel input stage: quadrature
// state encodings, speed ceiling and the default debounce counter width.
package spin_control_input_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam logic [2:0] SPEED_MAX = 3'd7;

  localparam int DEFAULT_DEBOUNCE_WIDTH = 16;

endpackage

// File: rtl/spin_control_input_if.sv
// Front-panel raw inputs and spinner control outputs bundled together.
// master = the side driving the panel pins, slave = the input stage.
interface spin_control_input_if;

  logic       enc_a;
  logic       enc_b;
  logic       btn;
  logic [2:0] speed_sel;
  logic       direction;
  logic       step_pulse;
  logic       enc_err;

  modport master (
    output enc_a, enc_b, btn,
    input  speed_sel, direction, step_pulse, enc_err
  );

  modport slave (
    input  enc_a, enc_b, btn,
    output speed_sel, direction, step_pulse, enc_err
  );

endinterface

// File: rtl/spin_control_input_debounce_filter.sv
// Two-flop synchroniser followed by a stability counter. The debounced
// output only follows the synchronised input after it has differed from
// the current debounced value for DEBOUNCE_MAX+1 consecutive cycles.
module spin_control_input_debounce_filter
  import spin_control_input_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam logic [DEBOUNCE_WIDTH-1:0] DEBOUNCE_MAX = '1;

  logic                      sync_p0;
  logic                      sync_p1;
  logic [DEBOUNCE_WIDTH-1:0] cnt;

  // Stage p0/p1: bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Filter stage: count cycles of disagreement, accept once saturated.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_p1 == deb) begin
      cnt <= '0;
    end else if (cnt != DEBOUNCE_MAX) begin
      cnt <= cnt + 1'b1;
    end else begin
      deb <= sync_p1;
      cnt <= '0;
    end
  end

endmodule

// File: rtl/spin_control_input.sv
// Spinner control input stage: debounces encoder A/B and the pushbutton,
// decodes quadrature detents into a saturating 3-bit speed select and
// toggles direction on each button press. All outputs are registered.
module spin_control_input
  import spin_control_input_pkg::*;
#(
  parameter int         DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH,
  parameter logic [2:0] SPEED_RESET    = 3'd4,
  parameter logic       DIR_RESET      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  spin_control_input_if.slave  bus
);

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == SPEED_MAX) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  logic       a_deb;
  logic       b_deb;
  logic       btn_deb;
  logic [1:0] cur_ab;
  logic [1:0] prev_ab;
  logic       btn_prev;
  logic       detent_cw;
  logic       detent_ccw;
  logic       quad_err;
  logic       btn_rise;
  logic [2:0] speed_q;
  logic       dir_q;
  logic       step_q;
  logic       err_q;

  spin_control_input_debounce_filter #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.enc_a),
    .deb   (a_deb)
  );

  spin_control_input_debounce_filter #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.enc_b),
    .deb   (b_deb)
  );

  spin_control_input_debounce_filter #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_deb_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn),
    .deb   (btn_deb)
  );

  // A detent is the return to 00; which neighbour it came from gives the sense.
  assign cur_ab     = {a_deb, b_deb};
  assign detent_cw  = (prev_ab == Q10) && (cur_ab == Q00);
  assign detent_ccw = (prev_ab == Q01) && (cur_ab == Q00);
  assign quad_err   = ((prev_ab ^ cur_ab) == 2'b11);
  assign btn_rise   = btn_deb & ~btn_prev;

  // Output stage: register decode results, track previous encoder/button state.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab  <= Q00;
      btn_prev <= 1'b0;
      speed_q  <= SPEED_RESET;
      dir_q    <= DIR_RESET;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_ab  <= cur_ab;
      btn_prev <= btn_deb;
      step_q   <= detent_cw | detent_ccw;
      err_q    <= quad_err;
      if (detent_cw) begin
        speed_q <= sat_inc(speed_q);
      end else if (detent_ccw) begin
        speed_q <= sat_dec(speed_q);
      end
      if (btn_rise) begin
        dir_q <= ~dir_q;
      end
    end
  end

  assign bus.speed_sel  = speed_q;
  assign bus.direction  = dir_q;
  assign bus.step_pulse = step_q;
  assign bus.enc_err    = err_q;

endmodule

// File: tb/tb_spin_control_input.sv
// Self-checking bench for spin_control_input with a 4-bit debounce counter
// (inputs must be stable for 16 synchronised cycles to be accepted).
module tb_spin_control_input;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  spin_control_input_if bus ();

  spin_control_input #(.DEBOUNCE_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int steps  = 0;
  int errs   = 0;

  // Reference model: an input is accepted once its last 16 synchronised
  // samples (raw samples delayed by two clocks) all differ from the accepted
  // value; decode effects appear one clock after acceptance.
  logic [17:0] ha, hb, hbt;
  logic        m_a, m_b, m_bt, m_btn_prev, m_dir, m_step, m_err;
  logic [1:0]  m_prev, m_cur;
  logic [2:0]  m_speed;

  always @(posedge clk) begin
    if (reset) begin
      ha = '0; hb = '0; hbt = '0;
      m_a = 0; m_b = 0; m_bt = 0;
      m_prev = 2'b00; m_btn_prev = 0;
      m_speed = 3'd4; m_dir = 1; m_step = 0; m_err = 0;
    end else begin
      m_cur  = {m_a, m_b};
      m_step = 0;
      m_err  = 0;
      if (m_cur == 2'b00 && m_prev == 2'b10) begin
        m_step = 1;
        if (m_speed < 3'd7) m_speed = m_speed + 3'd1;
      end else if (m_cur == 2'b00 && m_prev == 2'b01) begin
        m_step = 1;
        if (m_speed > 3'd0) m_speed = m_speed - 3'd1;
      end else if (m_cur[0] != m_prev[0] && m_cur[1] != m_prev[1]) begin
        m_err = 1;
      end
      if (m_bt && !m_btn_prev) m_dir = !m_dir;
      m_prev     = m_cur;
      m_btn_prev = m_bt;
      ha  = {ha[16:0],  bus.enc_a};
      hb  = {hb[16:0],  bus.enc_b};
      hbt = {hbt[16:0], bus.btn};
      if (ha[17:2]  == {16{~m_a}})  m_a  = ~m_a;
      if (hb[17:2]  == {16{~m_b}})  m_b  = ~m_b;
      if (hbt[17:2] == {16{~m_bt}}) m_bt = ~m_bt;
    end
  end

  task automatic set_ab(input logic [1:0] ab);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
  endtask

  task automatic hold_ab(input logic [1:0] ab, input int n);
    set_ab(ab);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_count(input logic [1:0] ab, input int n);
    set_ab(ab);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.step_pulse) steps++;
      if (bus.enc_err) errs++;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    bus.enc_a = 0; bus.enc_b = 0; bus.btn = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    total++; if (bus.speed_sel !== 3'd4) $display("FAIL reset_speed got %0d want 4", bus.speed_sel); else passed++;
    total++; if (bus.direction !== 1'b1) $display("FAIL reset_dir got %b want 1", bus.direction); else passed++;
    total++; if (bus.step_pulse !== 1'b0) $display("FAIL reset_step got %b want 0", bus.step_pulse); else passed++;
    total++; if (bus.enc_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.enc_err); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_first_detent;
    hold_ab(2'b01, 20);
    hold_ab(2'b11, 20);
    hold_ab(2'b10, 20);
    total++; if (bus.speed_sel !== 3'd4) $display("FAIL pre_detent_speed got %0d want 4", bus.speed_sel); else passed++;
    set_ab(2'b00);
    repeat (18) @(posedge clk);
    #1;
    total++; if (bus.speed_sel !== 3'd4 || bus.step_pulse !== 1'b0)
      $display("FAIL detent_early got speed=%0d step=%b want speed=4 step=0", bus.speed_sel, bus.step_pulse); else passed++;
    @(posedge clk); #1;
    total++; if (bus.speed_sel !== 3'd5 || bus.step_pulse !== 1'b1)
      $display("FAIL detent_latency got speed=%0d step=%b want speed=5 step=1", bus.speed_sel, bus.step_pulse); else passed++;
    @(posedge clk); #1;
    total++; if (bus.step_pulse !== 1'b0) $display("FAIL step_width got %b want 0", bus.step_pulse); else passed++;
    hold_ab(2'b00, 5);
  endtask

  task automatic test_saturation;
    steps = 0; errs = 0;
    repeat (4) begin
      hold_count(2'b01, 20); hold_count(2'b11, 20);
      hold_count(2'b10, 20); hold_count(2'b00, 20);
    end
    total++; if (bus.speed_sel !== 3'd7) $display("FAIL sat_high_speed got %0d want 7", bus.speed_sel); else passed++;
    total++; if (steps !== 4) $display("FAIL sat_high_steps got %0d want 4", steps); else passed++;
    steps = 0;
    repeat (9) begin
      hold_count(2'b10, 20); hold_count(2'b11, 20);
      hold_count(2'b01, 20); hold_count(2'b00, 20);
    end
    total++; if (bus.speed_sel !== 3'd0) $display("FAIL sat_low_speed got %0d want 0", bus.speed_sel); else passed++;
    total++; if (steps !== 9) $display("FAIL sat_low_steps got %0d want 9", steps); else passed++;
    total++; if (errs !== 0) $display("FAIL sat_errs got %0d want 0", errs); else passed++;
  endtask

  task automatic test_button;
    bus.btn = 1; repeat (10) @(posedge clk);
    #1 bus.btn = 0; repeat (30) @(posedge clk); #1;
    total++; if (bus.direction !== 1'b1) $display("FAIL btn_glitch got %b want 1", bus.direction); else passed++;
    bus.btn = 1; repeat (25) @(posedge clk); #1;
    total++; if (bus.direction !== 1'b0) $display("FAIL btn_press got %b want 0", bus.direction); else passed++;
    bus.btn = 0; repeat (30) @(posedge clk); #1;
    total++; if (bus.direction !== 1'b0) $display("FAIL btn_release got %b want 0", bus.direction); else passed++;
  endtask

  task automatic test_enc_err;
    steps = 0; errs = 0;
    hold_count(2'b11, 25);
    total++; if (errs !== 1) $display("FAIL err_pulses got %0d want 1", errs); else passed++;
    total++; if (bus.speed_sel !== 3'd0 || steps !== 0)
      $display("FAIL err_speed got speed=%0d steps=%0d want speed=0 steps=0", bus.speed_sel, steps); else passed++;
    errs = 0;
    hold_count(2'b00, 25);
    total++; if (errs !== 1) $display("FAIL err_return got %0d want 1", errs); else passed++;
  endtask

  task automatic test_reset_mid_debounce;
    hold_ab(2'b10, 10);
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    total++; if (bus.speed_sel !== 3'd4 || bus.direction !== 1'b1 || bus.step_pulse !== 1'b0 || bus.enc_err !== 1'b0)
      $display("FAIL mid_reset_outputs got speed=%0d dir=%b step=%b err=%b want 4 1 0 0",
               bus.speed_sel, bus.direction, bus.step_pulse, bus.enc_err); else passed++;
    repeat (15) @(posedge clk);
    #1;
    steps = 0;
    hold_count(2'b00, 40);
    total++; if (steps !== 0 || bus.speed_sel !== 3'd4)
      $display("FAIL short_after_reset got steps=%0d speed=%0d want 0 4", steps, bus.speed_sel); else passed++;
    set_ab(2'b10);
    repeat (16) @(posedge clk);
    #1;
    hold_count(2'b00, 40);
    total++; if (steps !== 1 || bus.speed_sel !== 3'd5)
      $display("FAIL full_after_reset got steps=%0d speed=%0d want 1 5", steps, bus.speed_sel); else passed++;
  endtask

  task automatic test_random;
    int remain = 0;
    int r;
    logic [1:0] ab = {bus.enc_a, bus.enc_b};
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      total++; if (bus.speed_sel !== m_speed) $display("FAIL rand_speed cyc=%0d got %0d want %0d", cyc, bus.speed_sel, m_speed); else passed++;
      total++; if (bus.direction !== m_dir) $display("FAIL rand_dir cyc=%0d got %b want %b", cyc, bus.direction, m_dir); else passed++;
      total++; if (bus.step_pulse !== m_step) $display("FAIL rand_step cyc=%0d got %b want %b", cyc, bus.step_pulse, m_step); else passed++;
      total++; if (bus.enc_err !== m_err) $display("FAIL rand_err cyc=%0d got %b want %b", cyc, bus.enc_err, m_err); else passed++;
      if (remain == 0) begin
        r = $urandom_range(0, 9);
        if (r <= 5) ab = (r[0]) ? {ab[1], ~ab[0]} : {~ab[1], ab[0]};
        else if (r == 6) ab = ~ab;
        else bus.btn = ~bus.btn;
        set_ab(ab);
        remain = $urandom_range(1, 35);
      end
      remain--;
    end
  endtask

  initial begin
    bus.enc_a = 0; bus.enc_b = 0; bus.btn = 0;
    test_reset;
    test_first_detent;
    test_saturation;
    test_button;
    test_enc_err;
    test_reset_mid_debounce;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
